// File: rtl/instr_fetch_unit.sv
// Program sequencer feeding CPU_4bit: writable program memory, PC stepping,
// NOP bubbles when idle/stalled/halted, HALT detection, free-run or single-step.
module instr_fetch_unit #(
  parameter int         AW      = 4,
  parameter logic [2:0] HALT_OP = 3'b011
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  output logic [8:0]    Instruction,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted,
  output logic [7:0]    instr_count
);

  localparam int         DEPTH = 2**AW;
  localparam logic [8:0] NOP   = 9'b0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [8:0]    instr_q, instr_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    word;
  logic          issue;

  // Program memory is never reset; writes are only accepted outside RUN.
  always_ff @(posedge CLK) begin
    if (prog_we && state_q != S_RUN) mem_q[prog_addr] <= prog_data;
  end

  assign word  = mem_q[pc_q];
  assign issue = !step_mode || step;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = NOP;
    case (state_q)
      S_RUN: begin
        if (issue) begin
          if (word[8:6] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            instr_d = word;
            pc_d    = pc_q + AW'(1);
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  assign Instruction = instr_q;
  assign pc          = pc_q;
  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model.
module tb_instr_fetch_unit;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [8:0]    prog_data = '0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [8:0]    Instruction;
  logic [AW-1:0] pc;
  logic          running, halted;
  logic [7:0]    instr_count;

  instr_fetch_unit #(.AW(AW), .HALT_OP(3'b011)) dut (
    .CLK(CLK), .RST(RST), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
    .Instruction(Instruction), .pc(pc), .running(running), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Reference model: memory image plus architectural state.
  logic [8:0] mm [DEPTH];
  bit         m_run, m_halt;
  int         m_pc, m_cnt;
  int         m_ins;
  int         tick_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got=%0h exp=%0h", tag, tick_n, got, exp);
    end
  endtask

  task automatic model_step();
    if (prog_we && !m_run) mm[prog_addr] = prog_data;
    if (RST) begin
      m_run = 0; m_halt = 0; m_pc = 0; m_cnt = 0; m_ins = 0;
    end else if (m_run) begin
      m_ins = 0;
      if (!step_mode || step) begin
        if (mm[m_pc][8:6] == 3'b011) begin
          m_run = 0; m_halt = 1;
        end else begin
          m_ins = mm[m_pc];
          m_pc  = (m_pc + 1) % DEPTH;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
    end else begin
      m_ins = 0;
      if (start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_cnt = 0;
      end
    end
  endtask

  // One clock: model advances with the inputs the DUT sampled, then all
  // outputs are compared 1ns after the edge; pulse inputs are cleared.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    tick_n++;
    chk("instr", 32'(Instruction), 32'(m_ins));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("running", 32'(running), 32'(m_run));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("count", 32'(instr_count), 32'(m_cnt));
    RST = 0; start = 0; step = 0; prog_we = 0;
  endtask

  task automatic load(input int addr, input logic [8:0] data);
    prog_we = 1; prog_addr = AW'(addr); prog_data = data;
    tick();
  endtask

  logic [8:0] prog [8];
  int nonnop;

  initial begin
    m_run = 0; m_halt = 0; m_pc = 0; m_cnt = 0; m_ins = 0; tick_n = 0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;

    // Reset held for two cycles
    RST = 1; tick(); RST = 1; tick();
    chk("rst_instr", 32'(Instruction), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flags", {30'd0, running, halted}, 0);
    chk("rst_count", 32'(instr_count), 0);

    for (int i = 0; i < DEPTH; i++) load(i, 9'h000);

    // Free-run test program ending in HALT at address 7
    prog = '{9'b100111110, 9'b100100011, 9'b000010001, 9'b001100101,
             9'b101010010, 9'b110001100, 9'b001011011, 9'b011000000};
    for (int i = 0; i < 8; i++) load(i, prog[i]);
    step_mode = 0;
    start = 1; tick();
    chk("start_nop", 32'(Instruction), 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("fr_word", 32'(Instruction), 32'(prog[i]));
    end
    tick();
    chk("fr_halted", 32'(halted), 1);
    chk("fr_pc", 32'(pc), 7);
    chk("fr_count", 32'(instr_count), 7);
    chk("fr_halt_nop", 32'(Instruction), 0);

    // Single-step: pulses at cycles 3, 4, 9 after start
    step_mode = 1;
    start = 1; tick();
    nonnop = 0;
    for (int c = 1; c <= 12; c++) begin
      step = (c == 3 || c == 4 || c == 9);
      tick();
      if (Instruction != 0) nonnop++;
    end
    chk("ss_issued", 32'(nonnop), 3);
    chk("ss_pc", 32'(pc), 3);
    chk("ss_count", 32'(instr_count), 3);
    step_mode = 0;

    // Wrap: no HALT anywhere, 20 issue cycles
    for (int i = 0; i < DEPTH; i++) load(i, 9'b000000001);
    start = 1; tick();
    for (int c = 0; c < 20; c++) tick();
    chk("wrap_pc", 32'(pc), 4);
    chk("wrap_count", 32'(instr_count), 20);
    chk("wrap_run", 32'(running), 1);
    // Keep going past 255 issues to exercise saturation
    for (int c = 0; c < 260; c++) tick();
    chk("sat_count", 32'(instr_count), 255);

    // Write during RUN is ignored; mid-run reset at cycle 4
    prog_we = 1; prog_addr = 2; prog_data = 9'b011000000; tick();
    RST = 1; tick();
    chk("mr_rst_run", 32'(running), 0);
    load(5, 9'b011000000);
    start = 1; tick();
    for (int c = 1; c <= 3; c++) tick();
    RST = 1; tick();
    chk("mr_instr", 32'(Instruction), 0);
    chk("mr_pc", 32'(pc), 0);
    chk("mr_idle", {30'd0, running, halted}, 0);
    start = 1; tick();
    for (int c = 0; c < 8; c++) tick();
    chk("wp_halt_at5", 32'(pc), 5);

    // Write + start on the same edge, HALT at address 0
    prog_we = 1; prog_addr = 0; prog_data = 9'b011000000; start = 1; tick();
    chk("ws_nop0", 32'(Instruction), 0);
    tick();
    chk("ws_halted", 32'(halted), 1);
    chk("ws_count", 32'(instr_count), 0);
    chk("ws_nop1", 32'(Instruction), 0);

    // Random phase
    for (int n = 0; n < 2000; n++) begin
      RST       = ($urandom_range(0, 63) == 0);
      start     = ($urandom_range(0, 7) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = AW'($urandom);
      prog_data = 9'($urandom);
      if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
      step      = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
